imm_packer: RTL and testbench
=============================

// Module: imm_packer
// PURPOSE
//  Inverse of the immediate extender: inserts a 32-bit immediate into the
//  immediate fields of a RISC-V instruction word for I/S/B/J formats.
//  Sits in the instruction-generation path (self-test program builder / JIT
//  patch unit). It is a 2-stage valid/ready pipeline with range checking
//  and a saturating error counter.
// PARAMETERS
//  ERR_CNT_W  8  width of err_count; saturates at 2**ERR_CNT_W-1
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid&&in_ready
//  in_base    in   32  instruction word; immediate-field bits are overwritten
//  in_imm     in   32  signed immediate (byte offset for B/J)
//  in_imm_src in   2   00=I 01=S 10=B 11=J (same encoding as extender ImmSrc)
//  out_valid  out  1   packed word valid
//  out_ready  in   1   consumer ready
//  out_instr  out  32  packed instruction
//  out_err    out  1   immediate not representable; travels with out_instr
//  err_clr    in   1   synchronous clear of err_count
//  err_count  out  ERR_CNT_W  count of packed words issued with out_err=1
// BEHAVIOUR
//  Reset: s1/s2 valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0.
//   Reset is async and may occur mid-transfer; in-flight words are dropped.
//  S1 (capture+check): on accept, register base/imm/src and err flag:
//   I,S: err = ~(imm[31:11] all equal)
//   B:   err = ~(imm[31:12] all equal) | imm[0]
//   J:   err = ~(imm[31:20] all equal) | imm[0]
//  S2 (pack), output register; base bits outside the fields pass through:
//   I: [31:20]=imm[11:0]
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//   On err, the word is still packed from the truncated bits; it is never dropped.
//  Latency: accept in cycle N -> out_valid in cycle N+2 if not stalled.
//  Throughput: 1 word/cycle. Stage k advances when !valid_k || next ready.
//   in_ready = !s1_valid || s2_ready; s2_ready = !out_valid || out_ready.
//   in_ready is combinational from out_ready; the module holds no other comb paths.
//  While out_valid && !out_ready: out_instr/out_err are held stable.
//   Order is preserved, nothing is lost or duplicated, and max 2 words are in flight.
//  err_count increments by 1 on each output handshake with out_err=1 and
//   saturates (does not wrap). If err_clr and an error handshake occur in
//   the same cycle, clear wins and err_count=0.
// TESTING
//  1 I: base=0x00000013 imm=0xFFFFFFFF src=00 -> out_instr=0xFFF00013,
//    out_err=0, out_valid exactly 2 cycles after accept.
//  2 S: base=0x00002023 imm=0x000007FF src=01 -> 0x7E002FA3, err=0;
//    imm=0x00000800 -> err=1, err_count=1.
//  3 B: imm=0x00000003 src=10 -> out_err=1 (misaligned); imm=0xFFFFF000
//    base=0x00000063 -> 0x80000063, err=0.
//  4 J: base=0x0000006F imm=0xFFFFFFFE src=11 -> 0xFFFFF06F, err=0.
//  5 Backpressure: out_ready=0, 4 back-to-back requests -> 2 accepted, then
//    in_ready=0. Release -> all 4 words exit in order, held stable while stalled.
//  6 Saturation/clear: with ERR_CNT_W=2, 5 errors -> err_count=3. Then err_clr
//    coincident with an error handshake -> 0. Then assert rst_n=0 mid-stream ->
//    out_valid=0 immediately.
//  Scoreboard: random imm/src; for err=0, feeding out_instr to the extender
//    returns in_imm.

Source files
------------

// File: rtl/imm_packer.sv
// imm_packer: packs a 32-bit immediate into RISC-V I/S/B/J instruction fields through a 2-stage valid/ready pipeline
module imm_packer #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_base,
  input  logic [31:0]          in_imm,
  input  logic [1:0]           in_imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_base_q, s1_imm_q;
  logic [1:0]           s1_src_q;
  logic                 s1_err_q, s1_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_instr_q, out_instr_d;
  logic                 out_err_q;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 s2_ready, s1_load, s2_load;
  logic                 hi11_ok, hi12_ok, hi20_ok;
  assign s2_ready  = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_ready;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid_q && s2_ready;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;
  // An immediate fits when every bit above the field's sign bit matches it
  assign hi11_ok = &in_imm[31:11] || ~|in_imm[31:11];
  assign hi12_ok = &in_imm[31:12] || ~|in_imm[31:12];
  assign hi20_ok = &in_imm[31:20] || ~|in_imm[31:20];
  always_comb begin
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_err_d    = in_imm_src[1] ? (!(in_imm_src[0] ? hi20_ok : hi12_ok) || in_imm[0]) : !hi11_ok;
    out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
    out_instr_d = (s1_src_q == SRC_I) ? {s1_imm_q[11:0], s1_base_q[19:0]} :
                  (s1_src_q == SRC_S) ? {s1_imm_q[11:5], s1_base_q[24:12], s1_imm_q[4:0], s1_base_q[6:0]} :
                  (s1_src_q == SRC_B) ? {s1_imm_q[12], s1_imm_q[10:5], s1_base_q[24:12], s1_imm_q[4:1],
                                         s1_imm_q[11], s1_base_q[6:0]} :
                                        {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                         s1_base_q[11:0]};
    err_count_d = err_clr ? '0 :
                  (out_valid_q && out_ready && out_err_q && err_count_q != '1) ? err_count_q + 1'b1 :
                  err_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_base_q   <= '0;
      s1_imm_q    <= '0;
      s1_src_q    <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      err_count_q <= err_count_d;
      if (s1_load) begin
        s1_base_q <= in_base;
        s1_imm_q  <= in_imm;
        s1_src_q  <= in_imm_src;
        s1_err_q  <= s1_err_d;
      end
      if (s2_load) begin
        out_instr_q <= out_instr_d;
        out_err_q   <= s1_err_q;
      end
    end
  end
endmodule

// File: tb/tb_imm_packer.sv
// tb_imm_packer: directed and round-trip scoreboard bench for imm_packer
module tb_imm_packer;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err, err_clr;
  logic [31:0] in_base, in_imm, out_instr;
  logic [1:0]  in_imm_src, err_count;
  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        rt;
    logic [31:0] imm;
    logic [31:0] base;
    logic [1:0]  src;
  } exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  bit          rand_bp = 1'b0;
  logic        hv = 1'b0, he;
  logic [31:0] hi;
  always #5 clk = ~clk;
  imm_packer #(.ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_imm_src(in_imm_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_clr(err_clr), .err_count(err_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ext(input logic [31:0] i, input logic [1:0] s);
    case (s)
      2'b00:   ext = {{20{i[31]}}, i[31:20]};
      2'b01:   ext = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   ext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: ext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction
  function automatic logic [31:0] fmask(input logic [1:0] s);
    fmask = (s == 2'b00) ? 32'hFFF0_0000 : (s == 2'b11) ? 32'hFFFF_F000 : 32'hFE00_0F80;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) hv = 1'b0;
    else begin
      if (hv && out_valid) begin
        chk("hold_instr", out_instr, hi);
        chk("hold_err", 32'(out_err), 32'(he));
      end
      hv = out_valid && !out_ready;
      hi = out_instr;
      he = out_err;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 32'(out_instr), 32'hDEAD_BEEF ^ out_instr);
        else begin
          exp_t e;
          e = q.pop_front();
          if (e.rt) begin
            chk("rt_err", 32'(out_err), 0);
            chk("rt_imm", ext(out_instr, e.src), e.imm);
            chk("rt_base", out_instr & ~fmask(e.src), e.base & ~fmask(e.src));
          end else begin
            chk("instr", out_instr, e.instr);
            chk("err", 32'(out_err), 32'(e.err));
          end
        end
      end
    end
  end
  task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s,
                      input logic [31:0] ei, input logic ee, input logic rt);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_base = b; in_imm = i; in_imm_src = s;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    else q.push_back('{ei, ee, rt, i, b, s});
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] r, imm;
    logic [1:0]  s;
    rst_n = 1'b0; in_valid = 1'b0; in_base = '0; in_imm = '0; in_imm_src = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    send(32'h0000_0013, 32'hFFFF_FFFF, 2'b00, 32'hFFF0_0013, 1'b0, 1'b0);
    chk("lat_cycle1", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_cycle2", 32'(out_valid), 1);
    drain();
    send(32'h0000_2023, 32'h0000_07FF, 2'b01, 32'h7E00_2FA3, 1'b0, 1'b0);
    send(32'h0000_2023, 32'h0000_0800, 2'b01, 32'h8000_2023, 1'b1, 1'b0);
    drain();
    chk("s_err_count", 32'(err_count), 1);
    send(32'h0000_0063, 32'h0000_0003, 2'b10, 32'h0000_0163, 1'b1, 1'b0);
    send(32'h0000_0063, 32'hFFFF_F000, 2'b10, 32'h8000_0063, 1'b0, 1'b0);
    drain();
    chk("b_err_count", 32'(err_count), 2);
    send(32'h0000_006F, 32'hFFFF_FFFE, 2'b11, 32'hFFFF_F06F, 1'b0, 1'b0);
    drain();
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h0000_0001, 2'b00, 32'h0010_0013, 1'b0, 1'b0);
    send(32'h0000_0013, 32'h0000_0002, 2'b00, 32'h0020_0013, 1'b0, 1'b0);
    in_valid = 1'b1; in_base = 32'h0000_0013; in_imm = 32'h0000_0003; in_imm_src = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_instr", out_instr, 32'h0010_0013);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0000_0013, 32'h0000_0003, 2'b00, 32'h0030_0013, 1'b0, 1'b0);
    send(32'h0000_0013, 32'h0000_0004, 2'b00, 32'h0040_0013, 1'b0, 1'b0);
    drain();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_err_count", 32'(err_count), 0);
    repeat (5) send(32'h0000_0013, 32'h0000_0800, 2'b00, 32'h8000_0013, 1'b1, 1'b0);
    drain();
    chk("sat_err_count", 32'(err_count), 3);
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h0000_0800, 2'b00, 32'h8000_0013, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("coinc_out_valid", 32'(out_valid), 1);
    err_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("coinc_err_count", 32'(err_count), 0);
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h0000_0005, 2'b00, 32'h0050_0013, 1'b0, 1'b0);
    send(32'h0000_0013, 32'h0000_0006, 2'b00, 32'h0060_0013, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      s = 2'(k % 4);
      imm = (s[1] == 1'b0) ? {{20{r[11]}}, r[11:0]} :
            (s[0] == 1'b0) ? {{19{r[12]}}, r[12:1], 1'b0} : {{11{r[20]}}, r[20:1], 1'b0};
      send($urandom, imm, s, 32'h0, 1'b0, 1'b1);
    end
    rand_bp = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
